sync_c1tx_fifo: RTL and testbench
=================================

Name: sync_c1tx_fifo

Overview:
Synchronous single-clock FIFO used to buffer CCI-P Tx-side records, e.g. MMIO read responses queued before arbitration onto the shared c2 Tx channel. It carries a data word plus an optional control sideband. Status flags (valid, empty, full, count, almost-full, error pulses) are combinational/T0. Popped data appears on the output two clocks after the read acknowledge (T2).

Parameters:
DATA_WIDTH, 64, width of fifo_din / T2_fifo_dout in bits.
CTL_WIDTH, 0, control sideband width; 0 means no sideband, and the ctl ports are then 1 bit, with the input ignored and the output driven 0.
DEPTH_BASE2, 3, log2 of the entry count; depth D = 2**DEPTH_BASE2.
GRAM_MODE, 3, storage inference hint; any value is legal and the T2 latency is identical for every value.
FULL_THRESH, 2, almost-full slack; almFull asserts when count >= D - FULL_THRESH; legal range 1..D.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  synchronous, active-high reset.
fifo_din  in  DATA_WIDTH  write data.
fifo_ctlin  in  max(CTL_WIDTH,1)  write control sideband.
fifo_wen  in  1  write enable.
fifo_rdack  in  1  pop acknowledge for the head entry.
T2_fifo_dout  out  DATA_WIDTH  popped data, valid 2 clocks after rdack.
T0_fifo_ctlout  out  max(CTL_WIDTH,1)  head-entry control, combinational.
T0_fifo_dout_v  out  1  head entry present (= !empty).
T0_fifo_empty  out  1  count == 0.
T0_fifo_full  out  1  count == D.
T0_fifo_count  out  DEPTH_BASE2+1  occupancy, 0..D.
T0_fifo_almFull  out  1  count >= D - FULL_THRESH.
T0_fifo_underflow  out  1  one-cycle error pulse.
T0_fifo_overflow  out  1  one-cycle error pulse.

Behaviour:
- Reset: write pointer, read pointer and count go to 0; T2_fifo_dout, both pipeline stages and the error pulses clear to 0. After reset, empty=1, dout_v=0, full=0, and almFull=1 only if FULL_THRESH >= D. Any entries present when reset asserts mid-operation are discarded.
- Storage: D-entry circular array of {ctl,data}. Pointers are DEPTH_BASE2 bits and wrap modulo D.
- Write acceptance: a write is accepted when wen && (!full || rdack). An accepted write stores at wptr and advances wptr. The entry is visible at the head on the next cycle.
- Read acceptance: a read is accepted when rdack && !empty. The head entry is captured into stage T1 and rptr advances. On the next clock T1 moves to T2_fifo_dout. T2_fifo_dout holds its value when no read occurs.
- Count update: count' = count + acceptedWrite - acceptedRead. Simultaneous write and read leaves the count unchanged.
- Overflow: wen && full && !rdack pulses T0_fifo_overflow in the same cycle. The write is dropped and the contents are unchanged.
- Underflow: rdack && empty pulses T0_fifo_underflow in the same cycle. The pointers are unchanged. A simultaneous write is still accepted.
- Status outputs: T0_fifo_ctlout, empty, full, count and almFull are derived from the current registered state with no added latency.
- Throughput: back-to-back reads at 1 per clock are supported. Asserting rdack whenever dout_v is high drains one entry per clock, each appearing at T2 two clocks later in FIFO order.

Optional Feature:
SYNC_FIFO_ASSERT_EN.
- When defined: simulation-only checks are compiled in. On any overflow or underflow pulse the block issues a $display with the instance path and cycle, then calls $fatal. Each clock it also checks that count equals the pointer difference (mod D, with the full case resolved by the count) and that count <= D.
- When undefined: no checker code is compiled and the error pulses remain the only indication. Synthesized logic is identical in both cases.

Test Plan:
- D=4 (DEPTH_BASE2=2), FULL_THRESH=2, data width 64. Write 0xA,0xB,0xC,0xD on 4 consecutive clocks -> count 1,2,3,4; almFull asserts when count reaches 2; full=1 at count 4; dout_v=1 from the cycle after the first write.
- Full FIFO from above, wen with din 0xE and no rdack -> overflow pulses exactly 1 cycle; count stays 4; subsequent drain returns A,B,C,D only.
- Full FIFO, drive rdack while dout_v for 4 clocks -> T2_fifo_dout shows A,B,C,D on cycles n+2..n+5; empty=1, count=0 after the last pop.
- Empty FIFO, rdack=1 -> underflow pulse 1 cycle; count stays 0; T2_fifo_dout unchanged.
- Count=2, wen and rdack together for 6 clocks with incrementing data -> count stays 2; outputs emerge in order; pointers wrap past index 3 correctly.
- Count=3, assert reset for 1 clock -> count=0, empty=1, T2_fifo_dout=0, no error pulses; a following write/read round-trip returns the new data only.

Source files
------------

// File: rtl/sync_c1tx_fifo.sv
// -----------------------------------------------------------------------------
// sync_c1tx_fifo
//   Single-clock FIFO that buffers CCI-P Tx-side records (data word plus an
//   optional control sideband) ahead of arbitration onto a shared Tx channel.
//   Status flags are combinational from the registered state (T0). Popped data
//   appears on T2_fifo_dout two clocks after the read acknowledge (T2).
//
// Optional build macro: SYNC_FIFO_ASSERT_EN
//   When defined, a simulation-only checker is compiled in. It stops the run
//   on any overflow/underflow pulse and checks count/pointer consistency every
//   clock. Synthesized logic is identical with or without the macro.
//
// Ports:
//   clk               in   clock, all state on rising edge
//   reset             in   synchronous, active-high reset
//   fifo_din          in   write data                      [DATA_WIDTH]
//   fifo_ctlin        in   write control sideband          [max(CTL_WIDTH,1)]
//   fifo_wen          in   write enable
//   fifo_rdack        in   pop acknowledge for head entry
//   T2_fifo_dout      out  popped data, 2 clocks after rdack
//   T0_fifo_ctlout    out  head-entry control (0 when CTL_WIDTH == 0)
//   T0_fifo_dout_v    out  head entry present
//   T0_fifo_empty     out  count == 0
//   T0_fifo_full      out  count == D
//   T0_fifo_count     out  occupancy 0..D                 [DEPTH_BASE2+1]
//   T0_fifo_almFull   out  count >= D - FULL_THRESH
//   T0_fifo_underflow out  rdack while empty (1-cycle pulse)
//   T0_fifo_overflow  out  wen while full without rdack (1-cycle pulse)
// -----------------------------------------------------------------------------

`ifdef SYNC_FIFO_ASSERT_EN
// Simulation-only consistency checker bound into the FIFO top.
module sync_c1tx_fifo_chk #(
  parameter int DEPTH_BASE2 = 3
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   i_overflow,
  input logic                   i_underflow,
  input logic [DEPTH_BASE2-1:0] i_wptr,
  input logic [DEPTH_BASE2-1:0] i_rptr,
  input logic [DEPTH_BASE2:0]   i_count
);
  localparam int D = 1 << DEPTH_BASE2;

  logic [31:0]            r_cycle;
  logic [DEPTH_BASE2-1:0] w_diff;

  assign w_diff = i_wptr - i_rptr;

  // Cycle counter used to timestamp reported errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // Error pulse trap and count/pointer consistency check.
  always @(posedge clk) begin
    if (!reset) begin
      if (i_overflow) begin
        $display("%m: overflow at cycle %0d", r_cycle);
        $fatal(1, "%m: overflow");
      end
      if (i_underflow) begin
        $display("%m: underflow at cycle %0d", r_cycle);
        $fatal(1, "%m: underflow");
      end
      if (32'(i_count) > 32'(D)) begin
        $fatal(1, "%m: count %0d exceeds depth at cycle %0d", i_count, r_cycle);
      end
      // Equal pointers are ambiguous; the count must then be 0 or D.
      if (i_count[DEPTH_BASE2-1:0] != w_diff) begin
        $fatal(1, "%m: count %0d != pointer difference %0d at cycle %0d",
               i_count, w_diff, r_cycle);
      end
    end
  end
endmodule
`endif

module sync_c1tx_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int CTL_WIDTH   = 0,
  parameter int DEPTH_BASE2 = 3,
  parameter int GRAM_MODE   = 3,
  parameter int FULL_THRESH = 2,
  localparam int CW = (CTL_WIDTH > 0) ? CTL_WIDTH : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  fifo_din,
  input  logic [CW-1:0]          fifo_ctlin,
  input  logic                   fifo_wen,
  input  logic                   fifo_rdack,
  output logic [DATA_WIDTH-1:0]  T2_fifo_dout,
  output logic [CW-1:0]          T0_fifo_ctlout,
  output logic                   T0_fifo_dout_v,
  output logic                   T0_fifo_empty,
  output logic                   T0_fifo_full,
  output logic [DEPTH_BASE2:0]   T0_fifo_count,
  output logic                   T0_fifo_almFull,
  output logic                   T0_fifo_underflow,
  output logic                   T0_fifo_overflow
);
  localparam int                   D       = 1 << DEPTH_BASE2;
  localparam logic [DEPTH_BASE2:0] L_DEPTH = (DEPTH_BASE2+1)'(D);
  localparam logic [DEPTH_BASE2:0] L_ALM   = (DEPTH_BASE2+1)'(D - FULL_THRESH);
  // Storage style hint only; it does not change behaviour or latency.
  localparam logic [31:0]          L_GRAM  = GRAM_MODE;

  logic [DATA_WIDTH-1:0]  r_mem_data [D];
  logic [DEPTH_BASE2-1:0] r_wptr;
  logic [DEPTH_BASE2-1:0] r_rptr;
  logic [DEPTH_BASE2:0]   r_count;
  logic                   r_t1_v;
  logic [DATA_WIDTH-1:0]  r_t1_data;
  logic [DATA_WIDTH-1:0]  r_t2_data;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_unused_sink;

  assign w_empty  = (r_count == {(DEPTH_BASE2+1){1'b0}});
  assign w_full   = (r_count == L_DEPTH);
  // A write into a full FIFO is still accepted when the head is popped in the
  // same cycle: the popped slot is the one being overwritten, and its old
  // contents are captured into T1 on the same edge.
  assign w_wr_acc = !reset && fifo_wen && (!w_full || fifo_rdack);
  assign w_rd_acc = !reset && fifo_rdack && !w_empty;

  assign T0_fifo_empty     = w_empty;
  assign T0_fifo_dout_v    = !w_empty;
  assign T0_fifo_full      = w_full;
  assign T0_fifo_count     = r_count;
  assign T0_fifo_almFull   = (r_count >= L_ALM);
  assign T0_fifo_overflow  = !reset && fifo_wen && w_full && !fifo_rdack;
  assign T0_fifo_underflow = !reset && fifo_rdack && w_empty;
  assign T2_fifo_dout      = r_t2_data;

  // Data storage array; no reset needed since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem_data[r_wptr] <= fifo_din;
    end
  end

  generate
    if (CTL_WIDTH > 0) begin : g_ctl
      logic [CW-1:0] r_mem_ctl [D];

      // Control sideband storage, written alongside the data word.
      always_ff @(posedge clk) begin
        if (w_wr_acc) begin
          r_mem_ctl[r_wptr] <= fifo_ctlin;
        end
      end

      assign T0_fifo_ctlout = r_mem_ctl[r_rptr];
      assign w_unused_sink  = L_GRAM[0];
    end else begin : g_noctl
      assign T0_fifo_ctlout = {CW{1'b0}};
      assign w_unused_sink  = ^{fifo_ctlin, L_GRAM[0]};
    end
  endgenerate

  // Write/read pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= {DEPTH_BASE2{1'b0}};
      r_rptr  <= {DEPTH_BASE2{1'b0}};
      r_count <= {(DEPTH_BASE2+1){1'b0}};
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + DEPTH_BASE2'(1);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + DEPTH_BASE2'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (DEPTH_BASE2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_BASE2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Two-stage read pipeline: head captured into T1, then moved to T2 output.
  // T2 only updates when T1 holds a fresh pop, so it holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_t1_v    <= 1'b0;
      r_t1_data <= {DATA_WIDTH{1'b0}};
      r_t2_data <= {DATA_WIDTH{1'b0}};
    end else begin
      r_t1_v <= w_rd_acc;
      if (w_rd_acc) begin
        r_t1_data <= r_mem_data[r_rptr];
      end
      if (r_t1_v) begin
        r_t2_data <= r_t1_data;
      end
    end
  end

`ifdef SYNC_FIFO_ASSERT_EN
  sync_c1tx_fifo_chk #(
    .DEPTH_BASE2 (DEPTH_BASE2)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .i_overflow  (T0_fifo_overflow),
    .i_underflow (T0_fifo_underflow),
    .i_wptr      (r_wptr),
    .i_rptr      (r_rptr),
    .i_count     (r_count)
  );
`endif

endmodule

// File: tb/tb_sync_c1tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_c1tx_fifo
//   Self-checking bench for sync_c1tx_fifo (D=4, FULL_THRESH=2, 64-bit data,
//   4-bit control sideband). A queue-based reference model tracks contents;
//   popped words are scheduled to appear at T2 two clocks after the pop.
// -----------------------------------------------------------------------------
module tb_sync_c1tx_fifo;
  localparam int DW = 64;
  localparam int CW = 4;
  localparam int AW = 2;
  localparam int D  = 4;
  localparam int FT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo_din;
  logic [CW-1:0] fifo_ctlin;
  logic          fifo_wen;
  logic          fifo_rdack;
  logic [DW-1:0] T2_fifo_dout;
  logic [CW-1:0] T0_fifo_ctlout;
  logic          T0_fifo_dout_v;
  logic          T0_fifo_empty;
  logic          T0_fifo_full;
  logic [AW:0]   T0_fifo_count;
  logic          T0_fifo_almFull;
  logic          T0_fifo_underflow;
  logic          T0_fifo_overflow;

  always #5 clk = ~clk;

  sync_c1tx_fifo #(
    .DATA_WIDTH  (DW),
    .CTL_WIDTH   (CW),
    .DEPTH_BASE2 (AW),
    .GRAM_MODE   (3),
    .FULL_THRESH (FT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_din          (fifo_din),
    .fifo_ctlin        (fifo_ctlin),
    .fifo_wen          (fifo_wen),
    .fifo_rdack        (fifo_rdack),
    .T2_fifo_dout      (T2_fifo_dout),
    .T0_fifo_ctlout    (T0_fifo_ctlout),
    .T0_fifo_dout_v    (T0_fifo_dout_v),
    .T0_fifo_empty     (T0_fifo_empty),
    .T0_fifo_full      (T0_fifo_full),
    .T0_fifo_count     (T0_fifo_count),
    .T0_fifo_almFull   (T0_fifo_almFull),
    .T0_fifo_underflow (T0_fifo_underflow),
    .T0_fifo_overflow  (T0_fifo_overflow)
  );

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } pend_t;

  ent_t          mq[$];
  pend_t         pq[$];
  logic [DW-1:0] exp_t2;
  int            cyc;
  int            n_vec;
  int            n_err;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    int n;
    n = mq.size();
    chk("count",   64'(T0_fifo_count),   64'(n));
    chk("empty",   64'(T0_fifo_empty),   64'(n == 0));
    chk("full",    64'(T0_fifo_full),    64'(n == D));
    chk("dout_v",  64'(T0_fifo_dout_v),  64'(n != 0));
    chk("almFull", 64'(T0_fifo_almFull), 64'(n >= D - FT));
    if (n != 0) begin
      chk("ctlout", 64'(T0_fifo_ctlout), 64'(mq[0].c));
    end
  endtask

  task automatic step(input logic wen, input logic [DW-1:0] din, input logic rdack);
    logic          rd;
    logic          wr;
    int            n;
    logic [CW-1:0] c;
    ent_t          e;
    @(negedge clk);
    c          = CW'($urandom);
    fifo_wen   = wen;
    fifo_din   = din;
    fifo_ctlin = c;
    fifo_rdack = rdack;
    #1;
    n = mq.size();
    check_status();
    chk("overflow",  64'(T0_fifo_overflow),  64'(wen && (n == D) && !rdack));
    chk("underflow", 64'(T0_fifo_underflow), 64'(rdack && (n == 0)));
    rd = rdack && (n != 0);
    wr = wen && ((n != D) || rdack);
    @(posedge clk);
    #1;
    cyc++;
    if (rd) begin
      e = mq.pop_front();
      pq.push_back('{due: cyc + 1, d: e.d});
    end
    if (wr) begin
      mq.push_back('{c: c, d: din});
    end
    while (pq.size() != 0 && pq[0].due == cyc) begin
      exp_t2 = pq[0].d;
      void'(pq.pop_front());
    end
    chk("t2_dout", T2_fifo_dout, exp_t2);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    reset      = 1'b1;
    fifo_wen   = 1'b0;
    fifo_rdack = 1'b0;
    fifo_din   = '0;
    repeat (ncyc) @(posedge clk);
    #1;
    chk("rst_overflow",  64'(T0_fifo_overflow),  64'd0);
    chk("rst_underflow", 64'(T0_fifo_underflow), 64'd0);
    mq.delete();
    pq.delete();
    exp_t2 = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_status();
    chk("rst_t2_dout", T2_fifo_dout, exp_t2);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    cyc        = 0;
    exp_t2     = '0;
    reset      = 1'b1;
    fifo_din   = '0;
    fifo_ctlin = '0;
    fifo_wen   = 1'b0;
    fifo_rdack = 1'b0;

    do_reset(2);

    // Fill to full with A..D.
    step(1'b1, 64'hA, 1'b0);
    step(1'b1, 64'hB, 1'b0);
    step(1'b1, 64'hC, 1'b0);
    step(1'b1, 64'hD, 1'b0);

    // Write into full FIFO: overflow pulse, contents unchanged.
    step(1'b1, 64'hE, 1'b0);
    step(1'b0, 64'h0, 1'b0);

    // Drain at one per clock, then let T2 settle.
    repeat (4) step(1'b0, 64'h0, 1'b1);
    repeat (2) step(1'b0, 64'h0, 1'b0);

    // Underflow on empty, alone and with a simultaneous write.
    step(1'b0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b0);
    step(1'b1, 64'h55, 1'b1);
    step(1'b1, 64'h56, 1'b0);

    // Count held at 2 with concurrent write/read; pointers wrap.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 64'h100 + 64'(i), 1'b1);
    end
    repeat (2) step(1'b0, 64'h0, 1'b1);
    repeat (2) step(1'b0, 64'h0, 1'b0);

    // Reset with 3 entries queued, then a fresh round trip.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 64'h200 + 64'(i), 1'b0);
    end
    do_reset(1);
    step(1'b1, 64'h300, 1'b0);
    step(1'b0, 64'h0, 1'b1);
    repeat (2) step(1'b0, 64'h0, 1'b0);

    // Randomized traffic: write-heavy then read-heavy.
    repeat (150) step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 3) == 0);
    repeat (150) step($urandom_range(0, 3) == 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    repeat (150) step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    repeat (6) step(1'b0, 64'h0, 1'b1);
    repeat (2) step(1'b0, 64'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
